// File: rtl/stochastic_adder.sv
// rtl/stochastic_adder.sv - scaled stochastic adder with registered output and per-stream ones counters
module stochastic_adder #(
    parameter int BIT_LENGTH = 128,
    parameter int CNT_W      = $clog2(BIT_LENGTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             rand_bit,
    output logic             y,
    output logic             y_q,
    output logic             y_valid,
    output logic [CNT_W-1:0] bit_idx,
    output logic [CNT_W-1:0] ones_a,
    output logic [CNT_W-1:0] ones_b,
    output logic [CNT_W-1:0] ones_y,
    output logic             stream_done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BIT_LENGTH - 1);

    logic             w_y;
    logic             w_last;
    logic [CNT_W-1:0] w_inc_a;
    logic [CNT_W-1:0] w_inc_b;
    logic [CNT_W-1:0] w_inc_y;

    logic             r_y_q;
    logic             r_y_valid;
    logic             r_stream_done;
    logic [CNT_W-1:0] r_bit_idx;
    logic [CNT_W-1:0] r_acc_a;
    logic [CNT_W-1:0] r_acc_b;
    logic [CNT_W-1:0] r_acc_y;
    logic [CNT_W-1:0] r_ones_a;
    logic [CNT_W-1:0] r_ones_b;
    logic [CNT_W-1:0] r_ones_y;

    // Select between the two streams; halves the sum of the input probabilities.
    assign w_y     = rand_bit ? b : a;
    assign w_last  = (r_bit_idx == LAST_IDX);
    assign w_inc_a = r_acc_a + CNT_W'(a);
    assign w_inc_b = r_acc_b + CNT_W'(b);
    assign w_inc_y = r_acc_y + CNT_W'(w_y);

    // Output register, stream accumulators and completed-stream result latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y_q         <= 1'b0;
            r_y_valid     <= 1'b0;
            r_stream_done <= 1'b0;
            r_bit_idx     <= '0;
            r_acc_a       <= '0;
            r_acc_b       <= '0;
            r_acc_y       <= '0;
            r_ones_a      <= '0;
            r_ones_b      <= '0;
            r_ones_y      <= '0;
        end else begin
            r_stream_done <= 1'b0;
            r_y_valid     <= in_valid;
            if (in_valid) begin
                r_y_q <= w_y;
            end
            if (clear) begin
                // Restart the stream; the bit presented alongside clear is dropped.
                r_bit_idx <= '0;
                r_acc_a   <= '0;
                r_acc_b   <= '0;
                r_acc_y   <= '0;
            end else if (in_valid) begin
                if (w_last) begin
                    r_ones_a      <= w_inc_a;
                    r_ones_b      <= w_inc_b;
                    r_ones_y      <= w_inc_y;
                    r_acc_a       <= '0;
                    r_acc_b       <= '0;
                    r_acc_y       <= '0;
                    r_bit_idx     <= '0;
                    r_stream_done <= 1'b1;
                end else begin
                    r_acc_a   <= w_inc_a;
                    r_acc_b   <= w_inc_b;
                    r_acc_y   <= w_inc_y;
                    r_bit_idx <= r_bit_idx + 1'b1;
                end
            end
        end
    end

    assign y           = w_y;
    assign y_q         = r_y_q;
    assign y_valid     = r_y_valid;
    assign bit_idx     = r_bit_idx;
    assign ones_a      = r_ones_a;
    assign ones_b      = r_ones_b;
    assign ones_y      = r_ones_y;
    assign stream_done = r_stream_done;

endmodule

// File: tb/tb_stochastic_adder.sv
// tb/tb_stochastic_adder.sv - self-checking bench for stochastic_adder
module tb_stochastic_adder;

    localparam int BL    = 128;
    localparam int CNT_W = $clog2(BL + 1);

    logic             clk = 1'b0;
    logic             rst_n, clear, in_valid, a, b, rand_bit;
    logic             y, y_q, y_valid, stream_done;
    logic [CNT_W-1:0] bit_idx, ones_a, ones_b, ones_y;

    stochastic_adder #(.BIT_LENGTH(BL)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .a(a), .b(b), .rand_bit(rand_bit), .y(y), .y_q(y_q),
        .y_valid(y_valid), .bit_idx(bit_idx), .ones_a(ones_a),
        .ones_b(ones_b), .ones_y(ones_y), .stream_done(stream_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int done_count = 0;

    // Reference model: bits of the stream in progress, plus last completed result.
    bit qa[$], qb[$], qy[$];
    int exp_ones_a = 0, exp_ones_b = 0, exp_ones_y = 0;
    bit exp_done = 0, exp_yq = 0, exp_yv = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int count_ones(input bit q[$]);
        int n = 0;
        foreach (q[i]) n += q[i];
        return n;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".y_q"}, y_q, exp_yq);
        check({tag, ".y_valid"}, y_valid, exp_yv);
        check({tag, ".stream_done"}, stream_done, exp_done);
        check({tag, ".bit_idx"}, bit_idx, qa.size());
        check({tag, ".ones_a"}, ones_a, exp_ones_a);
        check({tag, ".ones_b"}, ones_b, exp_ones_b);
        check({tag, ".ones_y"}, ones_y, exp_ones_y);
    endtask

    task automatic step(input bit va, input bit vb, input bit vs, input bit vld, input bit clr);
        bit ym;
        @(negedge clk);
        a = va; b = vb; rand_bit = vs; in_valid = vld; clear = clr;
        ym = vs ? vb : va;
        #1;
        check("comb.y", y, ym);
        @(posedge clk);
        #1;
        exp_done = 0;
        if (vld) begin exp_yq = ym; exp_yv = 1; end else exp_yv = 0;
        if (clr) begin
            qa.delete(); qb.delete(); qy.delete();
        end else if (vld) begin
            qa.push_back(va); qb.push_back(vb); qy.push_back(ym);
            if (qa.size() == BL) begin
                exp_ones_a = count_ones(qa);
                exp_ones_b = count_ones(qb);
                exp_ones_y = count_ones(qy);
                exp_done = 1;
                qa.delete(); qb.delete(); qy.delete();
            end
        end
        if (stream_done === 1'b1) done_count++;
        check_all("step");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1; clear = 1'b0; a = 1'b1; b = 1'b1; rand_bit = 1'b0;
        @(posedge clk);
        #1;
        qa.delete(); qb.delete(); qy.delete();
        exp_ones_a = 0; exp_ones_b = 0; exp_ones_y = 0;
        exp_done = 0; exp_yq = 0; exp_yv = 0;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] mux_tab;
        int         total_y;
        int         base_done;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; a = 1'b0; b = 1'b0; rand_bit = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // 1: exhaustive combinational table indexed by {a,b,rand_bit}
        mux_tab = 8'b1101_1000;
        for (int i = 0; i < 8; i++) begin
            a = i[2]; b = i[1]; rand_bit = i[0];
            #1;
            check("tab.y", y, mux_tab[i]);
        end

        // 2: a all ones, b all zeros, select alternating
        for (int i = 0; i < BL; i++) step(1'b1, 1'b0, i[0], 1'b1, 1'b0);
        check("t2.ones_a", ones_a, 128);
        check("t2.ones_b", ones_b, 0);
        check("t2.ones_y", ones_y, 64);
        check("t2.done_count", done_count, 1);

        // 3: reset right after the completed stream clears everything
        do_reset();

        // 4: clear after 50 bits, then a full a=b=1 stream
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        base_done = done_count;
        for (int i = 0; i < BL; i++) step(1'b1, 1'b1, $urandom_range(1), 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t4.ones_a", ones_a, 128);
        check("t4.ones_y", ones_y, 128);
        check("t4.done_once", done_count - base_done, 1);

        // 5: 128 valid bits with 40 idle cycles interleaved
        for (int i = 0; i < BL; i++) begin
            step($urandom_range(1), $urandom_range(1), $urandom_range(1), 1'b1, 1'b0);
            if ((i % 3 == 2) && (i < 120))
                step($urandom_range(1), $urandom_range(1), $urandom_range(1), 1'b0, 1'b0);
        end

        // 6: random streams, P(a)=0.25, P(b)=0.75, P(sel)=0.5
        total_y = 0;
        for (int s = 0; s < 500; s++) begin
            for (int i = 0; i < BL; i++)
                step($urandom_range(3) == 0, $urandom_range(3) != 0, $urandom_range(1), 1'b1, 1'b0);
            total_y += ones_y;
        end
        check("t6.mean_in_range", (total_y >= 30720 && total_y <= 33280) ? 1 : 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
